cbfp_stream_ctrl: RTL and testbench

Streaming controller for the stage-0 convergent block floating point (CBFP) normalisation. It accepts butterfly-02 outputs one complex sample per cycle and collects them into 64-sample blocks in a two-bank ping-pong buffer. While each block fills, it tracks the minimum redundant-sign-bit count across both components. It then replays the block with a common shift applied and reports the block exponent index alongside each sample, replacing the 512-wide combinational CBFP stage with a serial, backpressure-aware block between butterfly stage 0 and stage 1.

---
 rtl/cbfp_stream_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_cbfp_stream_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbfp_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cbfp_stream_ctrl
//  Purpose  : Serial stage-0 convergent block floating point controller.
//             Collects butterfly-02 outputs into BLOCK_LEN-sample blocks in a
//             two-bank ping-pong buffer, tracks the minimum redundant-sign-bit
//             count of each block while it fills, then replays the block with
//             a common shift and reports the block exponent with each sample.
//  Ports    :
//    clk_i             clock, rising edge
//    rst_n_i           synchronous active-low reset
//    in_valid_i        input sample valid
//    in_ready_o        controller can accept a sample
//    in_re_i, in_im_i  signed input sample (WIDTH)
//    out_valid_o       output sample valid
//    out_ready_i       downstream accepts output
//    out_re_o/out_im_o signed normalised sample (WIDTH)
//    out_index_o       block exponent (minimum sign count) of this sample
//    out_last_o        last sample of a block
//    out_frame_last_o  last sample of the last block of a frame
//  Revision : 1.0  initial release
// ============================================================================
module cbfp_stream_ctrl #(
   parameter int WIDTH     = 23,
   parameter int BLOCK_LEN = 64,
   parameter int N_BLOCK   = 8,
   parameter int SHIFT_REF = 12
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic signed [WIDTH-1:0] in_re_i,
   input  logic signed [WIDTH-1:0] in_im_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic signed [WIDTH-1:0] out_re_o,
   output logic signed [WIDTH-1:0] out_im_o,
   output logic [5:0]              out_index_o,
   output logic                    out_last_o,
   output logic                    out_frame_last_o
);

   localparam int              c_cnt_w     = $clog2(BLOCK_LEN);
   localparam int              c_blk_w     = (N_BLOCK > 1) ? $clog2(N_BLOCK) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BLOCK_LEN - 1);
   localparam logic [c_blk_w-1:0] c_blk_last = c_blk_w'(N_BLOCK - 1);
   localparam logic [5:0]      c_min_init  = 6'd63;
   localparam logic [5:0]      c_shift_ref = 6'(SHIFT_REF);

   typedef enum logic [1:0] {
      RD_IDLE   = 2'd0,
      RD_STREAM = 2'd1,
      RD_HOLD   = 2'd2
   } rd_state_t;

   typedef enum logic [0:0] {
      WR_FILL  = 1'b0,
      WR_STALL = 1'b1
   } wr_state_t;

   // Number of bits below the MSB that are copies of the sign bit.
   function automatic logic [5:0] f_sign_cnt(input logic [WIDTH-1:0] x);
      logic [5:0] n;
      logic       run;
      n   = 6'd0;
      run = 1'b1;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         if (run && (x[i] == x[WIDTH-1])) begin
            n = n + 6'd1;
         end else begin
            run = 1'b0;
         end
      end
      return n;
   endfunction

   // Common block shift: left when the block has headroom beyond the
   // reference, arithmetic right otherwise. Result is truncated to WIDTH.
   function automatic logic signed [WIDTH-1:0] f_norm(input logic signed [WIDTH-1:0] x,
                                                      input logic [5:0]              c);
      if (c >= c_shift_ref) begin
         return x <<< (c - c_shift_ref);
      end else begin
         return x >>> (c_shift_ref - c);
      end
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic signed [WIDTH-1:0] mem_re_q [2*BLOCK_LEN];
   logic signed [WIDTH-1:0] mem_im_q [2*BLOCK_LEN];

   logic [1:0]         full_q,    full_d;
   logic               wr_bank_q, wr_bank_d;
   logic [c_cnt_w-1:0] wr_cnt_q,  wr_cnt_d;
   logic [5:0]         run_min_q, run_min_d;
   logic [5:0]         idx_q [2];
   logic [5:0]         idx_d [2];
   logic               rd_bank_q, rd_bank_d;
   logic [c_cnt_w-1:0] rd_cnt_q,  rd_cnt_d;
   logic [c_blk_w-1:0] blk_cnt_q;
   wr_state_t          wr_state_q;
   rd_state_t          rd_state_q;

   logic signed [WIDTH-1:0] out_re_q, out_im_q;
   logic [5:0]              out_index_q;
   logic                    out_last_q, out_frame_last_q;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic                    accept;
   logic                    load;
   logic [5:0]              sc_re, sc_im, sample_min, run_min_new;
   logic [5:0]              cur_idx;
   logic signed [WIDTH-1:0] rd_re, rd_im;

   assign in_ready_o  = (wr_state_q == WR_FILL);
   assign out_valid_o = (rd_state_q != RD_IDLE);
   assign accept      = in_valid_i && in_ready_o;
   assign load        = full_q[rd_bank_q] && (!out_valid_o || out_ready_i);

   assign sc_re       = f_sign_cnt(in_re_i);
   assign sc_im       = f_sign_cnt(in_im_i);
   assign sample_min  = (sc_re < sc_im) ? sc_re : sc_im;
   assign run_min_new = (sample_min < run_min_q) ? sample_min : run_min_q;

   assign cur_idx     = idx_q[rd_bank_q];
   assign rd_re       = mem_re_q[{rd_bank_q, rd_cnt_q}];
   assign rd_im       = mem_im_q[{rd_bank_q, rd_cnt_q}];

   assign out_re_o         = out_re_q;
   assign out_im_o         = out_im_q;
   assign out_index_o      = out_index_q;
   assign out_last_o       = out_last_q;
   assign out_frame_last_o = out_frame_last_q;

   // ------------------------------------------------------------------------
   // Next-state for the bank bookkeeping. A write only targets a non-full
   // bank and a read only targets a full bank, so set and clear of full
   // never collide on the same bank.
   // ------------------------------------------------------------------------
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      wr_cnt_d  = wr_cnt_q;
      run_min_d = run_min_q;
      idx_d     = idx_q;
      rd_bank_d = rd_bank_q;
      rd_cnt_d  = rd_cnt_q;

      if (accept) begin
         if (wr_cnt_q == c_cnt_last) begin
            idx_d[wr_bank_q]  = run_min_new;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_cnt_d          = '0;
            run_min_d         = c_min_init;
         end else begin
            wr_cnt_d  = wr_cnt_q + 1'b1;
            run_min_d = run_min_new;
         end
      end

      if (load) begin
         if (rd_cnt_q == c_cnt_last) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_cnt_d          = '0;
         end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
         end
      end
   end

   // Sample storage carries no reset; validity is tracked by full_q.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         mem_re_q[{wr_bank_q, wr_cnt_q}] <= in_re_i;
         mem_im_q[{wr_bank_q, wr_cnt_q}] <= in_im_i;
      end
   end

   // ------------------------------------------------------------------------
   // Bookkeeping registers and both FSMs with registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         full_q           <= 2'b00;
         wr_bank_q        <= 1'b0;
         wr_cnt_q         <= '0;
         run_min_q        <= c_min_init;
         idx_q[0]         <= 6'd0;
         idx_q[1]         <= 6'd0;
         rd_bank_q        <= 1'b0;
         rd_cnt_q         <= '0;
         blk_cnt_q        <= '0;
         wr_state_q       <= WR_FILL;
         rd_state_q       <= RD_IDLE;
         out_re_q         <= '0;
         out_im_q         <= '0;
         out_index_q      <= 6'd0;
         out_last_q       <= 1'b0;
         out_frame_last_q <= 1'b0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         wr_cnt_q  <= wr_cnt_d;
         run_min_q <= run_min_d;
         idx_q     <= idx_d;
         rd_bank_q <= rd_bank_d;
         rd_cnt_q  <= rd_cnt_d;

         // Writer stalls whenever the bank it will write next is still full.
         wr_state_q <= full_d[wr_bank_d] ? WR_STALL : WR_FILL;

         // Frame position advances on every completed last-of-block handshake.
         if (out_valid_o && out_ready_i && out_last_q) begin
            blk_cnt_q <= (blk_cnt_q == c_blk_last) ? '0 : blk_cnt_q + 1'b1;
         end

         case (rd_state_q)
            RD_IDLE, RD_STREAM, RD_HOLD: begin
               if (load) begin
                  rd_state_q       <= RD_STREAM;
                  out_re_q         <= f_norm(rd_re, cur_idx);
                  out_im_q         <= f_norm(rd_im, cur_idx);
                  out_index_q      <= cur_idx;
                  out_last_q       <= (rd_cnt_q == c_cnt_last);
                  out_frame_last_q <= (rd_cnt_q == c_cnt_last) && (blk_cnt_q == c_blk_last);
               end else if (out_valid_o && !out_ready_i) begin
                  // Output frozen until downstream takes it.
                  rd_state_q <= RD_HOLD;
               end else begin
                  rd_state_q       <= RD_IDLE;
                  out_last_q       <= 1'b0;
                  out_frame_last_q <= 1'b0;
               end
            end
            default: rd_state_q <= RD_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cbfp_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cbfp_stream_ctrl
//  Purpose  : Scoreboard bench for cbfp_stream_ctrl. The input driver feeds
//             a reference model that computes each block's exponent and the
//             normalised samples; the output monitor pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cbfp_stream_ctrl;

   localparam int c_w   = 23;
   localparam int c_len = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [c_w-1:0]    in_re = '0;
   logic [c_w-1:0]    in_im = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [c_w-1:0]    out_re, out_im;
   logic [5:0]        out_index;
   logic              out_last, out_fl;

   cbfp_stream_ctrl #(
      .WIDTH     (23),
      .BLOCK_LEN (64),
      .N_BLOCK   (8),
      .SHIFT_REF (12)
   ) u_dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .in_valid_i       (in_valid),
      .in_ready_o       (in_ready),
      .in_re_i          (in_re),
      .in_im_i          (in_im),
      .out_valid_o      (out_valid),
      .out_ready_i      (out_ready),
      .out_re_o         (out_re),
      .out_im_o         (out_im),
      .out_index_o      (out_index),
      .out_last_o       (out_last),
      .out_frame_last_o (out_fl)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic t_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- ready generation ----------------
   logic rdy_rand  = 1'b0;
   logic rdy_fixed = 1'b0;
   always @(posedge clk) begin
      #1;
      out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_fixed;
   end

   // ---------------- reference model ----------------
   logic [53:0]    sb[$];
   logic [c_w-1:0] blk_re[$];
   logic [c_w-1:0] blk_im[$];
   int             blk_no = 0;

   // Sign count via position of the highest bit that differs from the sign.
   function automatic int f_sc(input logic [c_w-1:0] x);
      logic [c_w-1:0] y;
      int p;
      y = x[c_w-1] ? ~x : x;
      p = -1;
      for (int i = 0; i < c_w; i++) if (y[i]) p = i;
      return (c_w - 2) - p;
   endfunction

   function automatic logic [c_w-1:0] f_ref_shift(input logic [c_w-1:0] x, input int c);
      longint v;
      v = longint'($signed(x));
      if (c >= 12) v = v * (longint'(1) << (c - 12));
      else         v = v >>> (12 - c);
      return v[c_w-1:0];
   endfunction

   task automatic model_push(input logic [c_w-1:0] re, input logic [c_w-1:0] im);
      int mn;
      logic last, fl;
      blk_re.push_back(re);
      blk_im.push_back(im);
      if (blk_re.size() == c_len) begin
         mn = 63;
         for (int j = 0; j < c_len; j++) begin
            if (f_sc(blk_re[j]) < mn) mn = f_sc(blk_re[j]);
            if (f_sc(blk_im[j]) < mn) mn = f_sc(blk_im[j]);
         end
         for (int j = 0; j < c_len; j++) begin
            last = (j == c_len - 1);
            fl   = last && (blk_no == 7);
            sb.push_back({f_ref_shift(blk_re[j], mn), f_ref_shift(blk_im[j], mn),
                          6'(mn), last, fl});
         end
         blk_no = (blk_no + 1) % 8;
         blk_re.delete();
         blk_im.delete();
      end
   endtask

   // ---------------- driver ----------------
   int acc_cyc = 0;

   task automatic send(input logic [c_w-1:0] re, input logic [c_w-1:0] im);
      bit done;
      done = 0;
      in_valid = 1'b1;
      in_re    = re;
      in_im    = im;
      for (int k = 0; k < 1000 && !done; k++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      if (done) begin
         acc_cyc = cyc;
         model_push(re, im);
      end else begin
         t_check("send_timeout", 64'd0, 64'd1);
      end
   endtask

   function automatic logic [c_w-1:0] f_rnd(input int base);
      int t;
      t = int'($urandom);
      t = t >>> $urandom_range(base, 31);
      return t[c_w-1:0];
   endfunction

   // ---------------- monitor ----------------
   bit             hold_prev = 0;
   logic [63:0]    hold_snap = '0;
   bit             seen_valid = 0;
   int             first_valid_cyc = 0;
   int             hs_cnt = 0, first_hs = 0, last_hs = 0;
   logic [c_w-1:0] last_re = '0;
   logic [5:0]     last_idx = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (hold_prev)
            t_check("hold", {9'd0, out_valid, out_re, out_im, out_index, out_last, out_fl}, hold_snap);
         hold_prev = out_valid && !out_ready;
         hold_snap = {9'd0, out_valid, out_re, out_im, out_index, out_last, out_fl};
         if (out_valid && !seen_valid) begin
            seen_valid      = 1;
            first_valid_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               t_check("unexpected_output", 64'd1, 64'd0);
            end else begin
               t_check("out", {10'd0, out_re, out_im, out_index, out_last, out_fl},
                       {10'd0, sb.pop_front()});
            end
            last_re  = out_re;
            last_idx = out_index;
            hs_cnt++;
            if (hs_cnt == 1) first_hs = cyc;
            last_hs = cyc;
         end
      end else begin
         hold_prev = 0;
      end
   end

   task automatic drain(input int max_cyc);
      int k;
      k = 0;
      while (sb.size() > 0 && k < max_cyc) begin
         @(posedge clk);
         k++;
      end
      if (sb.size() > 0) t_check("drain_timeout", 64'(sb.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      t_check("rst_out", {9'd0, out_valid, out_re, out_im, out_index, out_last, out_fl}, 64'd0);
      t_check("rst_ready", 64'(in_ready), 64'd1);
      sb.delete();
      blk_re.delete();
      blk_im.delete();
      blk_no = 0;
      rst_n  = 1'b1;
   endtask

   task automatic clear_stats();
      seen_valid = 0;
      hs_cnt     = 0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      #1;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      rdy_fixed = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Block of ones: exponent 21, shift left by 9.
      clear_stats();
      for (int j = 0; j < c_len; j++) send(23'd1, 23'd0);
      in_valid = 1'b0;
      drain(500);
      t_check("t1_latency", 64'(first_valid_cyc - acc_cyc), 64'd1);
      t_check("t1_index", 64'(last_idx), 64'd21);
      t_check("t1_re", 64'(last_re), 64'd512);
      t_check("t1_count", 64'(hs_cnt), 64'd64);

      // One near-full-scale sample: exponent 0, shift right by 12.
      for (int j = 0; j < c_len; j++) send((j == 10) ? 23'h3FFFFF : 23'd0, 23'd0);
      in_valid = 1'b0;
      drain(500);
      t_check("t2_index", 64'(last_idx), 64'd0);

      // All -1: exponent 22, shift left by 10.
      for (int j = 0; j < c_len; j++) send('1, '1);
      in_valid = 1'b0;
      drain(500);
      t_check("t3_index", 64'(last_idx), 64'd22);
      t_check("t3_re", 64'(last_re), 64'h7FFC00);

      // Eight back-to-back random blocks from a fresh frame.
      do_reset();
      clear_stats();
      for (int b = 0; b < 8; b++) begin
         int base;
         base = $urandom_range(9, 31);
         for (int j = 0; j < c_len; j++) send(f_rnd(base), f_rnd(base));
      end
      in_valid = 1'b0;
      drain(1000);
      t_check("t4_count", 64'(hs_cnt), 64'd512);
      t_check("t4_gapless", 64'(last_hs - first_hs), 64'd511);

      // Backpressure: no output accepted, capacity two blocks.
      rdy_fixed = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      begin
         int acc;
         bit ok;
         acc = 0;
         for (int k = 0; k < 200; k++) begin
            logic [c_w-1:0] r, m;
            r = f_rnd(12);
            m = f_rnd(12);
            in_valid = 1'b1;
            in_re    = r;
            in_im    = m;
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
               acc++;
               model_push(r, m);
            end
         end
         in_valid = 1'b0;
         t_check("t5_accepts", 64'(acc), 64'd128);
         t_check("t5_ready_low", 64'(in_ready), 64'd0);
      end
      clear_stats();
      rdy_rand = 1'b1;
      drain(3000);
      rdy_rand  = 1'b0;
      rdy_fixed = 1'b1;
      t_check("t5_count", 64'(hs_cnt), 64'd128);

      // Reset in the middle of a block discards it.
      for (int j = 0; j < 40; j++) send(f_rnd(9), f_rnd(9));
      in_valid = 1'b0;
      do_reset();
      clear_stats();
      for (int j = 0; j < c_len; j++) send(f_rnd(20), f_rnd(20));
      in_valid = 1'b0;
      drain(500);
      t_check("t6_count", 64'(hs_cnt), 64'd64);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
